serial_adder_param: RTL and testbench
=====================================

# serial_adder_param

Parametrised bit-serial adder/subtractor, the sequential successor of the team's single-bit half/full adder cells. It computes one result bit per clock, LSB first, through a single full-adder slice and a carry flip-flop. Operands are loaded on a start handshake, and the registered result is flagged with a one-cycle done pulse. It is used wherever area matters more than latency, for example in accumulators or checksum units beside the combinational adder library.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal values are 2 to 64.

Ports:
- clk  input  1  Single clock domain; all state changes on the rising edge.
- rst_n  input  1  Synchronous, active-low reset, sampled on the rising edge of clk.
- Start  input  1  Request. Accepted only when the block is in IDLE or DONE.
- Sub  input  1  Mode select: 0 = A+B+Cin, 1 = A-B (computed as A + ~B + 1). Sampled with Start.
- A  input  WIDTH  Operand A, sampled with Start.
- B  input  WIDTH  Operand B, sampled with Start.
- Cin  input  1  Carry-in, used when Sub=0 and ignored when Sub=1. Sampled with Start.
- Busy  output  1  High while an operation is in progress (state RUN).
- Done  output  1  One-cycle pulse; Sum, Carry and Ovf are updated in the same cycle.
- Sum  output  WIDTH  Registered result. Holds its value until the next completion.
- Carry  output  1  Carry-out of the MSB. For Sub=1 this is the no-borrow flag: 1 iff A >= B as unsigned values.
- Ovf  output  1  Two's-complement signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- The FSM has three states: IDLE, RUN and DONE. It is encoded in 2 bits and reset to IDLE.
- Accept: in IDLE or DONE with Start=1, the block performs the following, then goes to RUN:
  - loads the A shift register with A;
  - loads the B shift register with B, or with ~B when Sub=1;
  - loads the carry flip-flop with Cin, or with 1 when Sub=1;
  - clears the bit counter.
- RUN edge behaviour:
  - The full-adder slice adds the LSBs of the A and B shift registers and the carry flip-flop.
  - The sum bit shifts into the MSB of the result shift register, and both operand registers shift right by one.
  - The carry flip-flop takes the slice carry-out.
  - The counter increments.
  - The slice carry-in on the final (MSB) bit is captured for Ovf.
- When the counter reaches WIDTH-1, the RUN edge does the following:
  - computes the MSB;
  - writes the complete result to Sum;
  - writes the final carry to Carry and the overflow to Ovf;
  - moves the FSM to DONE.
- DONE lasts one cycle. The next state is RUN if Start=1, otherwise IDLE.
- Start in RUN is ignored and does not queue. Operand inputs have no effect outside an accept edge.
- The counter is $clog2(WIDTH) bits wide and must not wrap during an operation.
- Sum, Carry and Ovf change only on the edge that enters DONE. They keep their old values during RUN.
- Reset (rst_n=0 at an edge), in any state including mid-RUN:
  - the FSM returns to IDLE;
  - Busy, Done, Sum, Carry, Ovf, the counter, the shift registers and the carry flip-flop all go to 0;
  - an aborted operation never produces a Done pulse.
- If Start is high in the same cycle as reset, reset wins.

## Timing
- Edge 0 is the accept edge. Busy is high after edge 0 through edge WIDTH-1.
- Done and the updated result are visible after edge WIDTH and stay for exactly one cycle.
- Latency from the accept edge to Done is WIDTH cycles.
- Back-to-back operation: Start held continuously gives one result every WIDTH+1 cycles, with DONE doubling as the accept cycle.
- Done is high for one cycle per completed operation and is never high together with Busy.
- Reset values: Busy=0, Done=0, Sum=0, Carry=0, Ovf=0.

## Test plan
All scenarios use WIDTH=8.
- Add wrap: A=8'hFF, B=8'h01, Cin=0, Sub=0 -> Sum=8'h00, Carry=1, Ovf=0. Done is asserted exactly 8 cycles after the accept edge, and Busy is high for 8 cycles.
- Signed overflow: A=8'h7F, B=8'h01, Cin=0 -> Sum=8'h80, Carry=0, Ovf=1. With A=8'h10, B=8'h20, Cin=1 -> Sum=8'h31, Carry=0, Ovf=0.
- Subtract: A=8'h05, B=8'h07, Sub=1 -> Sum=8'hFE, Carry=0, Ovf=0. A=8'h80, B=8'h01, Sub=1 -> Sum=8'h7F, Carry=1, Ovf=1.
- Start ignored while busy: pulse Start with new operands 3 cycles into RUN -> the first result is unaffected, and only one Done pulse occurs. Sum holds its previous value until the edge that enters DONE.
- Back-to-back: hold Start=1 with A=8'h01, B=8'h01, then A=8'h02, B=8'h02 presented on the DONE cycle -> Sum=8'h02, then Sum=8'h04. The two Done pulses are 9 cycles apart.
- Reset: assert rst_n=0 for one edge at RUN bit 4 -> all outputs read 0 and the block is in IDLE with no Done pulse. A fresh operation 8'h0A+8'h05 then returns 8'h0F.

Source files
------------

// File: rtl/serial_adder_param.sv
// Bit-serial adder/subtractor: one full-adder slice and a carry flip-flop produce
// one result bit per clock, LSB first, with a start handshake and a done pulse.
module serial_adder_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cy_q, cy_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;

    logic              slice_s;
    logic              slice_c;
    logic [WIDTH-1:0]  res_shift;

    assign slice_s   = a_q[0] ^ b_q[0] ^ cy_q;
    assign slice_c   = (a_q[0] & b_q[0]) | (cy_q & (a_q[0] ^ b_q[0]));
    assign res_shift = (res_q >> 1) | {slice_s, {(WIDTH-1){1'b0}}};

    // NOTE: every signal gets its hold value first so no path through the case leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = Sub ? ~B : B;
                    cy_d    = Sub ? 1'b1 : Cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift;
                cy_d  = slice_c;
                if (cnt_q == LAST_BIT) begin
                    // Counter holds on the MSB edge so it never wraps inside an operation.
                    sum_d   = res_shift;
                    carry_d = slice_c;
                    ovf_d   = cy_q ^ slice_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Busy  = (state_q == RUN);
    assign Done  = (state_q == DONE);
    assign Sum   = sum_q;
    assign Carry = carry_q;
    assign Ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder_param.sv
// Self-checking bench for serial_adder_param (WIDTH=8): scoreboard of expected
// results popped on each Done pulse, plus per-scenario timing and hold checks.
module tb_serial_adder_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       Start;
    logic       Sub;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic       Busy;
    logic       Done;
    logic [7:0] Sum;
    logic       Carry;
    logic       Ovf;

    serial_adder_param #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Start (Start),
        .Sub   (Sub),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Busy  (Busy),
        .Done  (Done),
        .Sum   (Sum),
        .Carry (Carry),
        .Ovf   (Ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } exp_t;

    exp_t       sb_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         done_cnt    = 0;
    logic [7:0] last_sum    = 8'h00;

    // Reference: plain 9-bit addition; overflow from operand/result sign bits.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic sub);
        exp_t       r;
        logic [7:0] bb;
        logic [8:0] full;
        bb      = sub ? ~b : b;
        full    = {1'b0, a} + {1'b0, bb} + {8'h00, (sub ? 1'b1 : cin)};
        r.sum   = full[7:0];
        r.carry = full[8];
        r.ovf   = (a[7] == bb[7]) && (full[7] != a[7]);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (Done === 1'b1 && Busy === 1'b1) begin
                miscompares++;
                $display("FAIL done_with_busy: Done and Busy both high at %0t", $time);
            end
            if (Done === 1'b1) begin
                exp_t e;
                done_cnt++;
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_done: Done pulse with empty scoreboard at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    if ({Sum, Carry, Ovf} !== {e.sum, e.carry, e.ovf}) begin
                        miscompares++;
                        $display("FAIL result: got Sum=%h Carry=%b Ovf=%b, expected Sum=%h Carry=%b Ovf=%b",
                                 Sum, Carry, Ovf, e.sum, e.carry, e.ovf);
                    end
                end
            end
        end
    end

    // One operation from IDLE/DONE; optionally pulses Start with other operands
    // inject_at cycles after acceptance. Checks latency, Busy length, hold and result.
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub, input logic [7:0] x_sum,
                          input logic x_carry, input logic x_ovf, input int inject_at);
        int lat;
        int busy_cnt;
        lat      = -1;
        busy_cnt = 0;
        Start = 1'b1; A = a; B = b; Cin = cin; Sub = sub;
        sb_q.push_back(model(a, b, cin, sub));
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) Start = 1'b0;
            if (i == inject_at) begin
                Start = 1'b1; A = 8'hFF; B = 8'hFF; Cin = 1'b1; Sub = 1'b0;
            end
            if (i == inject_at + 1) Start = 1'b0;
            if (Busy === 1'b1) begin
                busy_cnt++;
                vectors++;
                if (Sum !== last_sum) begin
                    miscompares++;
                    $display("FAIL %s_hold: Sum=%h during RUN, expected %h", name, Sum, last_sum);
                end
            end
            if (Done === 1'b1) begin
                lat = i - 1;
                break;
            end
        end
        vectors += 3;
        if (lat != 8) begin
            miscompares++;
            $display("FAIL %s_latency: Done after %0d cycles, expected 8", name, lat);
        end
        if (busy_cnt != 8) begin
            miscompares++;
            $display("FAIL %s_busy: Busy high %0d cycles, expected 8", name, busy_cnt);
        end
        if ({Sum, Carry, Ovf} !== {x_sum, x_carry, x_ovf}) begin
            miscompares++;
            $display("FAIL %s_value: got %h/%b/%b, expected %h/%b/%b",
                     name, Sum, Carry, Ovf, x_sum, x_carry, x_ovf);
        end
        last_sum = x_sum;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Start = 1'b1; Sub = 1'b0; A = 8'hFF; B = 8'hFF; Cin = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({Busy, Done, Sum, Carry, Ovf} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_values: Busy=%b Done=%b Sum=%h Carry=%b Ovf=%b, expected all 0",
                     Busy, Done, Sum, Carry, Ovf);
        end
        Start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({Busy, Done} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_idle: Busy=%b Done=%b after release, expected 0 0", Busy, Done);
        end
        last_sum = 8'h00;
    endtask

    task automatic test_add();
        run_op("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, -1);
        run_op("signed_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, -1);
        run_op("add_cin", 8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, -1);
    endtask

    task automatic test_sub();
        run_op("sub_borrow", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, -1);
        // Cin=1 must be ignored in subtract mode.
        run_op("sub_ovf", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, -1);
    endtask

    task automatic test_start_ignored();
        int d0;
        @(negedge clk);
        d0 = done_cnt;
        run_op("busy_start", 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0, 3);
        repeat (12) @(negedge clk);
        vectors += 2;
        if (done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL busy_start_pulses: %0d Done pulses, expected 1", done_cnt - d0);
        end
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL busy_start_queue: %0d results outstanding, expected 0", sb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int i1;
        int i2;
        i1 = -1;
        i2 = -1;
        @(negedge clk);
        Start = 1'b1; A = 8'h01; B = 8'h01; Cin = 1'b0; Sub = 1'b0;
        sb_q.push_back(model(8'h01, 8'h01, 1'b0, 1'b0));
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i1 >= 0 && i == i1 + 1) Start = 1'b0;
            if (Done === 1'b1) begin
                if (i1 < 0) begin
                    i1 = i;
                    vectors++;
                    if (Sum !== 8'h02) begin
                        miscompares++;
                        $display("FAIL b2b_first: Sum=%h, expected 02", Sum);
                    end
                    A = 8'h02; B = 8'h02;
                    sb_q.push_back(model(8'h02, 8'h02, 1'b0, 1'b0));
                end else begin
                    i2 = i;
                    break;
                end
            end
        end
        vectors += 2;
        if (Sum !== 8'h04 || i2 < 0) begin
            miscompares++;
            $display("FAIL b2b_second: Sum=%h seen=%0d, expected 04", Sum, i2 >= 0);
        end
        if (i2 - i1 != 9) begin
            miscompares++;
            $display("FAIL b2b_spacing: Done pulses %0d cycles apart, expected 9", i2 - i1);
        end
        Start = 1'b0;
        last_sum = 8'h04;
    endtask

    task automatic test_reset_mid_run();
        int d0;
        @(negedge clk);
        d0 = done_cnt;
        Start = 1'b1; A = 8'h33; B = 8'h44; Cin = 1'b0; Sub = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) Start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if ({Busy, Done, Sum, Carry, Ovf} !== 12'h000) begin
            miscompares++;
            $display("FAIL abort_values: Busy=%b Done=%b Sum=%h Carry=%b Ovf=%b, expected all 0",
                     Busy, Done, Sum, Carry, Ovf);
        end
        repeat (12) @(negedge clk);
        vectors++;
        if (done_cnt != d0) begin
            miscompares++;
            $display("FAIL abort_done: %0d Done pulses after abort, expected 0", done_cnt - d0);
        end
        last_sum = 8'h00;
        run_op("after_reset", 8'h0A, 8'h05, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        repeat (3) @(negedge clk);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL final_queue: %0d results never produced", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
